// File: rtl/sid_pkg.sv
// Shared definitions for the SID output stage: register map, mixer sequencer states,
// accumulator width and the 16-bit saturation helper.
package sid_pkg;

    localparam logic [4:0] ADDR_RES_FILT = 5'h17;
    localparam logic [4:0] ADDR_MODE_VOL = 5'h18;

    localparam int unsigned ACC_W = 19;

    typedef enum logic [3:0] {
        StIdle, StV0, StV1, StV2, StFlt, StM3, StM2, StM1, StM0, StOut
    } mix_state_e;

    typedef struct packed {
        logic [2:0] route;
        logic [3:0] vol;
        logic       mode_lp;
        logic       mode_bp;
        logic       mode_hp;
        logic       off3;
    } mix_cfg_t;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return 16'sh7fff;
        end else if (x < -32'sd32768) begin
            return 16'sh8000;
        end
        return x[15:0];
    endfunction

endpackage

// File: rtl/sid_mixer_if.sv
// Sample, register-bus and output signals of the SID mixer; the mixer takes the slave side.
interface sid_mixer_if;

    logic               clkEn;
    logic signed [15:0] iVoice0;
    logic signed [15:0] iVoice1;
    logic signed [15:0] iVoice2;
    logic signed [15:0] iLP;
    logic signed [15:0] iBP;
    logic signed [15:0] iHP;
    logic               WR;
    logic [4:0]         ADDR;
    logic [7:0]         DATA;
    logic signed [15:0] oFiltIn;
    logic signed [15:0] oOut;
    logic               oValid;

    modport master (
        output clkEn, iVoice0, iVoice1, iVoice2, iLP, iBP, iHP, WR, ADDR, DATA,
        input  oFiltIn, oOut, oValid
    );

    modport slave (
        input  clkEn, iVoice0, iVoice1, iVoice2, iLP, iBP, iHP, WR, ADDR, DATA,
        output oFiltIn, oOut, oValid
    );

endinterface

// File: rtl/sid_mixer_regs.sv
// Mixer register decode. Bus writes land in the register file; the sequencer only ever
// sees the snapshot taken on the sample strobe, so writes apply from the next sample.
module sid_mixer_regs
    import sid_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_i,
    input  logic [4:0] addr_i,
    input  logic [7:0] data_i,
    input  logic       start_i,
    output mix_cfg_t   cfg_o
);

    mix_cfg_t reg_d, reg_q;
    mix_cfg_t cfg_d, cfg_q;

    always_comb begin
        reg_d = reg_q;
        cfg_d = cfg_q;
        if (wr_i) begin
            // Upper nibble of the route register is the filter's resonance field.
            if (addr_i == ADDR_RES_FILT) begin
                reg_d.route = data_i[2:0];
            end else if (addr_i == ADDR_MODE_VOL) begin
                reg_d.vol     = data_i[3:0];
                reg_d.mode_lp = data_i[4];
                reg_d.mode_bp = data_i[5];
                reg_d.mode_hp = data_i[6];
                reg_d.off3    = data_i[7];
            end
        end
        if (start_i) begin
            cfg_d = reg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '0;
            cfg_q <= '0;
        end else begin
            reg_q <= reg_d;
            cfg_q <= cfg_d;
        end
    end

    assign cfg_o = cfg_q;

endmodule

// File: rtl/sid_mixer.sv
// SID output mixer: per sample, routes voices to the filter input or the direct path, adds
// the selected filter outputs, scales by master volume with a 4-step shift-add and saturates.
module sid_mixer #(
    parameter int unsigned ACC_W = sid_pkg::ACC_W
) (
    input logic        clk,
    input logic        rst_n,
    sid_mixer_if.slave bus
);
    import sid_pkg::*;

    localparam int unsigned PW = ACC_W + 4;

    mix_cfg_t                 cfg;
    mix_state_e               state_d, state_q;
    logic signed [15:0]       voice_d [3];
    logic signed [15:0]       voice_q [3];
    logic signed [15:0]       lp_d, lp_q, bp_d, bp_q, hp_d, hp_q;
    logic signed [ACC_W-1:0]  acc_dir_d, acc_dir_q, acc_flt_d, acc_flt_q;
    logic signed [PW-1:0]     prod_d, prod_q;
    logic signed [15:0]       filt_in_d, filt_in_q, out_d, out_q;
    logic                     valid_d, valid_q;
    logic                     add_voice, mul_step;
    logic [1:0]               vidx;
    logic [1:0]               vbit;

    sid_mixer_regs u_regs (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_i   (bus.WR),
        .addr_i (bus.ADDR),
        .data_i (bus.DATA),
        .start_i(bus.clkEn),
        .cfg_o  (cfg)
    );

    always_comb begin
        state_d   = state_q;
        voice_d   = voice_q;
        lp_d      = lp_q;
        bp_d      = bp_q;
        hp_d      = hp_q;
        acc_dir_d = acc_dir_q;
        acc_flt_d = acc_flt_q;
        prod_d    = prod_q;
        filt_in_d = filt_in_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        add_voice = 1'b0;
        mul_step  = 1'b0;
        vidx      = 2'd0;
        vbit      = 2'd0;

        // A strobe always wins: any running sequence restarts from the fresh snapshot.
        if (bus.clkEn) begin
            voice_d[0] = bus.iVoice0;
            voice_d[1] = bus.iVoice1;
            voice_d[2] = bus.iVoice2;
            lp_d       = bus.iLP;
            bp_d       = bus.iBP;
            hp_d       = bus.iHP;
            acc_dir_d  = '0;
            acc_flt_d  = '0;
            prod_d     = '0;
            state_d    = StV0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StV0:   begin add_voice = 1'b1; vidx = 2'd0; state_d = StV1;  end
                StV1:   begin add_voice = 1'b1; vidx = 2'd1; state_d = StV2;  end
                StV2:   begin add_voice = 1'b1; vidx = 2'd2; state_d = StFlt; end
                StFlt: begin
                    if (cfg.mode_lp) acc_dir_d = acc_dir_d + ACC_W'(lp_q);
                    if (cfg.mode_bp) acc_dir_d = acc_dir_d + ACC_W'(bp_q);
                    if (cfg.mode_hp) acc_dir_d = acc_dir_d + ACC_W'(hp_q);
                    filt_in_d = sat16(32'(acc_flt_q));
                    state_d   = StM3;
                end
                StM3:   begin mul_step = 1'b1; vbit = 2'd3; state_d = StM2;  end
                StM2:   begin mul_step = 1'b1; vbit = 2'd2; state_d = StM1;  end
                StM1:   begin mul_step = 1'b1; vbit = 2'd1; state_d = StM0;  end
                StM0:   begin mul_step = 1'b1; vbit = 2'd0; state_d = StOut; end
                StOut: begin
                    out_d   = sat16(32'(prod_q >>> 4));
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase

            // off3 only mutes voice 2 on the direct path, never when it feeds the filter.
            if (add_voice) begin
                if (cfg.route[vidx]) begin
                    acc_flt_d = acc_flt_q + ACC_W'(voice_q[vidx]);
                end else if (!(vidx == 2'd2 && cfg.off3)) begin
                    acc_dir_d = acc_dir_q + ACC_W'(voice_q[vidx]);
                end
            end

            if (mul_step) begin
                prod_d = prod_q <<< 1;
                if (cfg.vol[vbit]) prod_d = prod_d + PW'(acc_dir_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            voice_q   <= '{default: '0};
            lp_q      <= '0;
            bp_q      <= '0;
            hp_q      <= '0;
            acc_dir_q <= '0;
            acc_flt_q <= '0;
            prod_q    <= '0;
            filt_in_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            voice_q   <= voice_d;
            lp_q      <= lp_d;
            bp_q      <= bp_d;
            hp_q      <= hp_d;
            acc_dir_q <= acc_dir_d;
            acc_flt_q <= acc_flt_d;
            prod_q    <= prod_d;
            filt_in_q <= filt_in_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.oFiltIn = filt_in_q;
    assign bus.oOut    = out_q;
    assign bus.oValid  = valid_q;

endmodule

// File: tb/tb_sid_mixer.sv
// Self-checking bench for sid_mixer: directed cases plus randomized samples compared
// against an arithmetic model of the mix, routing and volume law.
module tb_sid_mixer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sid_mixer_if bus ();

    sid_mixer dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the programmed registers and of the last values the outputs should hold.
    int m_route = 0, m_vol = 0, m_lp = 0, m_bp = 0, m_hp = 0, m_off3 = 0;
    int prev_out = 0, prev_filt = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int clamp16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int rand16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [7:0] d);
        if (a == 5'h17) begin
            m_route = int'(d[2:0]);
        end else if (a == 5'h18) begin
            m_vol  = int'(d[3:0]);
            m_lp   = int'(d[4]);
            m_bp   = int'(d[5]);
            m_hp   = int'(d[6]);
            m_off3 = int'(d[7]);
        end
    endfunction

    // Expected filter input and output for one sample under the current model registers.
    task automatic model_mix(input int v0, v1, v2, lp, bp, hp, output int filt, output int out);
        int v[3];
        int direct, routed, p, q;
        v[0] = v0; v[1] = v1; v[2] = v2;
        direct = 0;
        routed = 0;
        for (int i = 0; i < 3; i++) begin
            if (((m_route >> i) & 1) == 1) routed += v[i];
            else if (!(i == 2 && m_off3 == 1)) direct += v[i];
        end
        if (m_lp == 1) direct += lp;
        if (m_bp == 1) direct += bp;
        if (m_hp == 1) direct += hp;
        p = direct * m_vol;
        q = p / 16;
        if (p < 0 && (p % 16) != 0) q = q - 1;
        filt = clamp16(routed);
        out  = clamp16(q);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [7:0] d);
        bus.WR   = 1'b1;
        bus.ADDR = a;
        bus.DATA = d;
        @(posedge clk); #1;
        bus.WR   = 1'b0;
        model_write(a, d);
    endtask

    task automatic drive_inputs(input int v0, v1, v2, lp, bp, hp);
        bus.iVoice0 = 16'(v0);
        bus.iVoice1 = 16'(v1);
        bus.iVoice2 = 16'(v2);
        bus.iLP     = 16'(lp);
        bus.iBP     = 16'(bp);
        bus.iHP     = 16'(hp);
    endtask

    task automatic scramble_inputs();
        drive_inputs(rand16(), rand16(), rand16(), rand16(), rand16(), rand16());
    endtask

    // One full sample; starts and ends 1 time unit after a rising edge.
    task automatic run_sample(input int v0, v1, v2, lp, bp, hp, input bit mid_wr,
                              input string tag);
        int ef, eo;
        logic [7:0] wd;
        model_mix(v0, v1, v2, lp, bp, hp, ef, eo);
        drive_inputs(v0, v1, v2, lp, bp, hp);
        bus.clkEn = 1'b1;
        @(posedge clk); #1;
        bus.clkEn = 1'b0;
        scramble_inputs();
        if (mid_wr) begin
            wd = 8'($urandom);
            bus.WR   = 1'b1;
            bus.ADDR = 5'h18;
            bus.DATA = wd;
            model_write(5'h18, wd);
        end
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            bus.WR = 1'b0;
            if (e == 3) check({tag, "_filt_hold"}, bus.oFiltIn, prev_filt);
            if (e == 4) check({tag, "_filt"}, bus.oFiltIn, ef);
            if (e == 8) begin
                check({tag, "_out_hold"}, bus.oOut, prev_out);
                check({tag, "_valid_early"}, bus.oValid, 0);
            end
            if (e == 9) begin
                check({tag, "_out"}, bus.oOut, eo);
                check({tag, "_valid"}, bus.oValid, 1);
            end
            if (e == 10) check({tag, "_valid_fall"}, bus.oValid, 0);
        end
        prev_filt = ef;
        prev_out  = eo;
    endtask

    initial begin
        int ef, eo, ef2, eo2;
        bus.clkEn = 1'b0;
        bus.WR    = 1'b0;
        bus.ADDR  = '0;
        bus.DATA  = '0;
        drive_inputs(0, 0, 0, 0, 0, 0);

        #2;
        check("reset_out", bus.oOut, 0);
        check("reset_filt", bus.oFiltIn, 0);
        check("reset_valid", bus.oValid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain direct path at near-full volume.
        write_reg(5'h17, 8'h00);
        write_reg(5'h18, 8'h0f);
        run_sample(1000, 2000, 3000, 111, 222, 333, 1'b0, "basic");

        // Routing of voices 0 and 2 plus the low-pass return; resonance bits ignored.
        write_reg(5'h17, 8'ha5);
        write_reg(5'h18, 8'h18);
        run_sample(4000, 100, 200, -300, 777, -888, 1'b0, "route");

        // Saturation at both rails.
        write_reg(5'h17, 8'h00);
        write_reg(5'h18, 8'h0f);
        run_sample(30000, 30000, 30000, 0, 0, 0, 1'b0, "sat_pos");
        run_sample(-30000, -30000, -30000, 0, 0, 0, 1'b0, "sat_neg");

        // off3 mutes voice 2 on the direct path only.
        write_reg(5'h18, 8'h8f);
        run_sample(0, 0, 5000, 0, 0, 0, 1'b0, "off3_mute");
        write_reg(5'h17, 8'h04);
        run_sample(0, 0, 5000, 0, 0, 0, 1'b0, "off3_routed");

        // Restart five cycles into a sequence: one pulse, carrying the second mix.
        write_reg(5'h17, 8'h01);
        write_reg(5'h18, 8'h7f);
        model_mix(1500, -2500, 700, 10, 20, 30, ef, eo);
        drive_inputs(1500, -2500, 700, 10, 20, 30);
        bus.clkEn = 1'b1;
        @(posedge clk); #1;
        bus.clkEn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("restart_first_filt", bus.oFiltIn, ef);
        model_mix(-6000, 9000, 1200, -40, 50, -60, ef2, eo2);
        drive_inputs(-6000, 9000, 1200, -40, 50, -60);
        bus.clkEn = 1'b1;
        @(posedge clk); #1;
        bus.clkEn = 1'b0;
        scramble_inputs();
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            check("restart_no_valid", bus.oValid, 0);
            check("restart_out_hold", bus.oOut, prev_out);
            if (e == 4) check("restart_filt", bus.oFiltIn, ef2);
        end
        @(posedge clk); #1;
        check("restart_out", bus.oOut, eo2);
        check("restart_valid", bus.oValid, 1);
        @(posedge clk); #1;
        check("restart_valid_fall", bus.oValid, 0);
        prev_out  = eo2;
        prev_filt = ef2;

        // Randomized samples, some with a register write landing mid-sequence.
        for (int i = 0; i < 20; i++) begin
            write_reg(5'h17, 8'($urandom));
            write_reg(5'h18, 8'($urandom));
            if (i % 4 == 0) write_reg(5'h16, 8'($urandom));
            run_sample(rand16(), rand16(), rand16(), rand16(), rand16(), rand16(),
                       1'($urandom), "rand");
        end

        // Reset mid-sequence clears outputs immediately; nothing runs until a new strobe.
        write_reg(5'h17, 8'h01);
        write_reg(5'h18, 8'h0f);
        drive_inputs(1234, 500, -700, 0, 0, 0);
        bus.clkEn = 1'b1;
        @(posedge clk); #1;
        bus.clkEn = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_filt", bus.oFiltIn, 1234);
        rst_n = 1'b0;
        #1;
        check("mid_reset_out", bus.oOut, 0);
        check("mid_reset_filt", bus.oFiltIn, 0);
        check("mid_reset_valid", bus.oValid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_route = 0; m_vol = 0; m_lp = 0; m_bp = 0; m_hp = 0; m_off3 = 0;
        prev_out = 0;
        prev_filt = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            check("post_reset_idle", bus.oValid, 0);
        end
        run_sample(3000, 3000, 3000, 0, 0, 0, 1'b0, "post_reset_zero_vol");
        write_reg(5'h17, 8'h02);
        write_reg(5'h18, 8'h3b);
        run_sample(rand16(), rand16(), rand16(), rand16(), rand16(), rand16(), 1'b0, "final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
